instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of instruction memory (depth 2**ADDR_W words).
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that terminates loading and execution.
REQ-003 CLK  input  1  system clock, all state updates on rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 INSTRUCTION_IN  input  32  instruction word from host/bench.
REQ-006 FLAG_I  input  1  INSTRUCTION_IN valid this cycle; one word accepted per cycle while high.
REQ-007 FLAG_STEP  input  1  step request; may be a single-cycle pulse; rising edge is the event.
REQ-008 MODE_CONT  input  1  1 = continuous run, 0 = single-step run; sampled on leaving READY only.
REQ-009 PC_HALTED  input  1  CPU has retired HALT_WORD.
REQ-010 IMEM_WE  output  1  instruction-memory write enable.
REQ-011 IMEM_ADDR  output  ADDR_W  instruction-memory write address.
REQ-012 IMEM_WDATA  output  32  instruction-memory write data.
REQ-013 CPU_RESET  output  1  holds CPU pipeline in reset.
REQ-014 CPU_EN  output  1  CPU clock enable (pipeline advances when high).
REQ-015 INSTR_COUNT  output  ADDR_W+1  number of words written, HALT_WORD included.
REQ-016 LOAD_DONE  output  1  program load complete.
REQ-017 OVERFLOW_ERR  output  1  memory filled without HALT_WORD; sticky until RESET.
REQ-018 STATE  output  3  encoded FSM state for debug: LOAD=0, READY=1, RUN=2, STEP=3, DONE=4.

Function
REQ-019 FSM states LOAD, READY, RUN, STEP, DONE; all outputs registered.
REQ-020 LOAD: FLAG_I=1 at edge k -> IMEM_WE=1, IMEM_WDATA=INSTRUCTION_IN, IMEM_ADDR=current write pointer during cycle k+1; pointer and INSTR_COUNT increment at edge k.
REQ-021 LOAD: FLAG_I=0 -> IMEM_WE=0, pointer held; gaps of any length allowed.
REQ-022 LOAD: accepted word equal to HALT_WORD is written, then FSM -> READY at same edge; LOAD_DONE=1 from next cycle.
REQ-023 LOAD: word accepted at address 2**ADDR_W-1 that is not HALT_WORD is written, OVERFLOW_ERR=1, FSM -> READY; pointer does not wrap.
REQ-024 FLAG_I outside LOAD ignored: IMEM_WE stays 0, pointer and INSTR_COUNT frozen.
REQ-025 CPU_RESET=1 in LOAD; CPU_RESET=0 in all other states.
REQ-026 CPU_EN=0 in LOAD, READY, DONE.
REQ-027 Step event = FLAG_STEP high at current edge and low at previous edge (one registered history bit); FLAG_STEP held high yields one event only.
REQ-028 READY: MODE_CONT=1 -> RUN next edge; MODE_CONT=0 -> STEP next edge; minimum one cycle in READY.
REQ-029 RUN: CPU_EN=1 every cycle until PC_HALTED=1 sampled; then CPU_EN=0 next cycle and FSM -> DONE.
REQ-030 STEP: each step event -> CPU_EN=1 for exactly one cycle (cycle after event edge); no event -> CPU_EN=0.
REQ-031 STEP: PC_HALTED=1 -> DONE; step event coincident with PC_HALTED is discarded.
REQ-032 Step events in LOAD, READY, RUN, DONE are discarded, not queued.
REQ-033 DONE: terminal; CPU_EN=0, LOAD_DONE=1; exit only via RESET.
REQ-034 MODE_CONT changes after leaving READY have no effect.

Reset
REQ-035 RESET=1 at an edge -> next cycle: STATE=LOAD, pointer=0, INSTR_COUNT=0, IMEM_WE=0, IMEM_ADDR=0, IMEM_WDATA=0, CPU_RESET=1, CPU_EN=0, LOAD_DONE=0, OVERFLOW_ERR=0, step history bit=0.
REQ-036 RESET overrides all inputs, including mid-load and mid-run; FLAG_I coincident with RESET is not written.

Verification
REQ-037 RESET, then words 0x20010005, 0x20020003, 0xFFFFFFFF on 3 consecutive cycles -> writes at addr 0,1,2; INSTR_COUNT=3; LOAD_DONE=1; CPU_RESET=0; STATE=READY.
REQ-038 Load with FLAG_I gaps (1,0,0,1,HALT) -> addresses contiguous 0,1,2; no IMEM_WE during gaps.
REQ-039 ADDR_W=2, 4 non-HALT words -> addr 0..3 written, OVERFLOW_ERR=1, 5th FLAG_I word ignored.
REQ-040 MODE_CONT=0, three 1-cycle FLAG_STEP pulses plus one 5-cycle-wide pulse -> exactly four 1-cycle CPU_EN pulses; PC_HALTED=1 -> STATE=DONE, later pulses give no CPU_EN.
REQ-041 MODE_CONT=1 -> CPU_EN continuous from RUN entry until cycle after PC_HALTED=1, then DONE.
REQ-042 RESET asserted during RUN -> all outputs at REQ-035 values next cycle; fresh load accepted from addr 0.

Source files
------------

// File: rtl/instr_loader.sv
// ----------------------------------------------------------------------------
// instr_loader
//
// Loads a program into instruction memory one word per cycle, then releases
// the CPU from reset and drives its clock enable in either continuous-run or
// single-step mode until the CPU reports that it has retired the halt word.
//
// Parameters
//   ADDR_W     word-address width of instruction memory (2**ADDR_W words)
//   HALT_WORD  encoding that terminates both loading and execution
//
// Ports
//   CLK             system clock, rising edge
//   RESET           synchronous, active-high reset
//   INSTRUCTION_IN  instruction word from host
//   FLAG_I          INSTRUCTION_IN valid; one word taken per cycle in LOAD
//   FLAG_STEP       step request; its rising edge is the event
//   MODE_CONT       1 = continuous run, 0 = single step (sampled in READY)
//   PC_HALTED       CPU has retired HALT_WORD
//   IMEM_WE/ADDR/WDATA  instruction-memory write port
//   CPU_RESET       holds the CPU pipeline in reset while loading
//   CPU_EN          CPU clock enable
//   INSTR_COUNT     number of words written, halt word included
//   LOAD_DONE       program load complete
//   OVERFLOW_ERR    memory filled without a halt word (sticky)
//   STATE           FSM state for debug: LOAD=0 READY=1 RUN=2 STEP=3 DONE=4
//
// Every output comes straight from a flop.
// ----------------------------------------------------------------------------
module instr_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION_IN,
    input  logic              FLAG_I,
    input  logic              FLAG_STEP,
    input  logic              MODE_CONT,
    input  logic              PC_HALTED,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [31:0]       IMEM_WDATA,
    output logic              CPU_RESET,
    output logic              CPU_EN,
    output logic [ADDR_W:0]   INSTR_COUNT,
    output logic              LOAD_DONE,
    output logic              OVERFLOW_ERR,
    output logic [2:0]        STATE
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_READY = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,     state_n;
    logic [ADDR_W-1:0]   ptr_q,       ptr_n;
    logic [ADDR_W:0]     count_q,     count_n;
    logic                we_q,        we_n;
    logic [ADDR_W-1:0]   addr_q,      addr_n;
    logic [31:0]         wdata_q,     wdata_n;
    logic                ovf_q,       ovf_n;
    logic                en_q,        en_n;
    logic                cpu_rst_q,   cpu_rst_n;
    logic                ld_done_q,   ld_done_n;
    logic                step_prev_q;
    logic                step_evt;

    // One history bit turns a level into an edge; a held FLAG_STEP gives
    // exactly one event, and an edge seen outside STEP is simply dropped.
    assign step_evt = FLAG_STEP & ~step_prev_q;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        count_n = count_q;
        we_n    = 1'b0;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        ovf_n   = ovf_q;
        en_n    = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                if (FLAG_I) begin
                    we_n    = 1'b1;
                    addr_n  = ptr_q;
                    wdata_n = INSTRUCTION_IN;
                    count_n = count_q + 1'b1;
                    // Pointer saturates on the last slot instead of wrapping.
                    if (ptr_q != PTR_MAX)
                        ptr_n = ptr_q + 1'b1;
                    if (INSTRUCTION_IN == HALT_WORD) begin
                        state_n = S_READY;
                    end else if (ptr_q == PTR_MAX) begin
                        ovf_n   = 1'b1;
                        state_n = S_READY;
                    end
                end
            end

            S_READY: begin
                // Raising the enable on this edge makes it continuous from
                // the very first RUN cycle.
                if (MODE_CONT) begin
                    state_n = S_RUN;
                    en_n    = 1'b1;
                end else begin
                    state_n = S_STEP;
                end
            end

            S_RUN: begin
                if (PC_HALTED)
                    state_n = S_DONE;
                else
                    en_n = 1'b1;
            end

            S_STEP: begin
                // A step coincident with halt is discarded.
                if (PC_HALTED)
                    state_n = S_DONE;
                else
                    en_n = step_evt;
            end

            S_DONE: begin
                state_n = S_DONE;
            end

            default: begin
                state_n = S_LOAD;
            end
        endcase

        cpu_rst_n = (state_n == S_LOAD);
        ld_done_n = (state_n != S_LOAD);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_LOAD;
            ptr_q       <= '0;
            count_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ovf_q       <= 1'b0;
            en_q        <= 1'b0;
            cpu_rst_q   <= 1'b1;
            ld_done_q   <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            ptr_q       <= ptr_n;
            count_q     <= count_n;
            we_q        <= we_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            ovf_q       <= ovf_n;
            en_q        <= en_n;
            cpu_rst_q   <= cpu_rst_n;
            ld_done_q   <= ld_done_n;
            step_prev_q <= FLAG_STEP;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign IMEM_WE      = we_q;
    assign IMEM_ADDR    = addr_q;
    assign IMEM_WDATA   = wdata_q;
    assign CPU_RESET    = cpu_rst_q;
    assign CPU_EN       = en_q;
    assign INSTR_COUNT  = count_q;
    assign LOAD_DONE    = ld_done_q;
    assign OVERFLOW_ERR = ovf_q;
    assign STATE        = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_loader
//
// Two loaders share one stimulus stream: a 256-word one (A) and a 4-word one
// (B) so that memory-full behaviour is exercised alongside normal loads.
// Load results are predicted from the word list alone; step/run behaviour is
// predicted from the pulse pattern applied.
// ----------------------------------------------------------------------------
module tb_instr_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET = 1'b1;
    logic [31:0] INSTRUCTION_IN = '0;
    logic        FLAG_I = 1'b0, FLAG_STEP = 1'b0, MODE_CONT = 1'b0, PC_HALTED = 1'b0;

    logic        a_we, a_cpu_reset, a_cpu_en, a_done, a_ovf;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_count;
    logic [2:0]  a_state;

    logic        b_we, b_cpu_reset, b_cpu_en, b_done, b_ovf;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;
    logic [2:0]  b_state;

    instr_loader #(.ADDR_W(8), .HALT_WORD(HALT)) dut_a (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION_IN(INSTRUCTION_IN), .FLAG_I(FLAG_I),
        .FLAG_STEP(FLAG_STEP), .MODE_CONT(MODE_CONT), .PC_HALTED(PC_HALTED),
        .IMEM_WE(a_we), .IMEM_ADDR(a_addr), .IMEM_WDATA(a_wdata), .CPU_RESET(a_cpu_reset),
        .CPU_EN(a_cpu_en), .INSTR_COUNT(a_count), .LOAD_DONE(a_done),
        .OVERFLOW_ERR(a_ovf), .STATE(a_state));

    instr_loader #(.ADDR_W(2), .HALT_WORD(HALT)) dut_b (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION_IN(INSTRUCTION_IN), .FLAG_I(FLAG_I),
        .FLAG_STEP(FLAG_STEP), .MODE_CONT(MODE_CONT), .PC_HALTED(PC_HALTED),
        .IMEM_WE(b_we), .IMEM_ADDR(b_addr), .IMEM_WDATA(b_wdata), .CPU_RESET(b_cpu_reset),
        .CPU_EN(b_cpu_en), .INSTR_COUNT(b_count), .LOAD_DONE(b_done),
        .OVERFLOW_ERR(b_ovf), .STATE(b_state));

    typedef struct { int addr; logic [31:0] data; } wr_t;
    typedef struct { bit v; logic [31:0] d; } stim_t;

    wr_t   wa_q[$], wb_q[$];
    stim_t stim_q[$];
    int    en_cycles = 0, en_pulses = 0;
    logic  en_prev = 1'b0;
    int    n_tests = 0, n_fail = 0;

    // Write / enable monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        wr_t w;
        if (a_we === 1'b1) begin w.addr = int'(a_addr); w.data = a_wdata; wa_q.push_back(w); end
        if (b_we === 1'b1) begin w.addr = int'(b_addr); w.data = b_wdata; wb_q.push_back(w); end
        if (a_cpu_en === 1'b1) begin
            en_cycles++;
            if (en_prev !== 1'b1) en_pulses++;
        end
        en_prev = a_cpu_en;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; FLAG_I = 1'b0; FLAG_STEP = 1'b0; PC_HALTED = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        stim_q.delete();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h1234_5678;
        return w;
    endfunction

    task automatic add(input bit v, input logic [31:0] d);
        stim_t s;
        s.v = v; s.d = d;
        stim_q.push_back(s);
    endtask

    // Plays stim_q into both loaders, then predicts writes, count, overflow
    // and the per-cycle state trace for each memory depth and compares.
    task automatic play_load(input string tag);
        int st_a[$], st_b[$];
        wa_q.delete(); wb_q.delete();
        foreach (stim_q[i]) begin
            FLAG_I = stim_q[i].v; INSTRUCTION_IN = stim_q[i].d;
            tick();
            st_a.push_back(int'(a_state)); st_b.push_back(int'(b_state));
        end
        FLAG_I = 1'b0; INSTRUCTION_IN = '0;
        repeat (2) begin
            tick();
            st_a.push_back(int'(a_state)); st_b.push_back(int'(b_state));
        end
        for (int k = 0; k < 2; k++) begin
            int depth, ptr, cstep, got_cnt, exp_st, got_st;
            bit ovf;
            logic got_ovf, got_done, got_crst;
            wr_t exp_q[$], got_q[$];
            depth = (k == 0) ? 256 : 4;
            ptr = 0; cstep = -1; ovf = 1'b0;
            for (int i = 0; i < stim_q.size(); i++) begin
                if (cstep < 0 && stim_q[i].v) begin
                    wr_t w;
                    w.addr = ptr; w.data = stim_q[i].d;
                    exp_q.push_back(w);
                    if (stim_q[i].d == HALT) cstep = i;
                    else if (ptr == depth - 1) begin ovf = 1'b1; cstep = i; end
                    ptr++;
                end
            end
            if (k == 0) begin
                got_q = wa_q; got_cnt = int'(a_count); got_ovf = a_ovf; got_done = a_done; got_crst = a_cpu_reset;
            end else begin
                got_q = wb_q; got_cnt = int'(b_count); got_ovf = b_ovf; got_done = b_done; got_crst = b_cpu_reset;
            end
            n_tests++;
            if (got_q.size() != exp_q.size()) begin n_fail++;
                $display("FAIL %s dut%0d write_count got %0d want %0d", tag, k, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_tests++;
                if (got_q[i].addr != exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin n_fail++;
                    $display("FAIL %s dut%0d write%0d got %0d:%h want %0d:%h", tag, k, i,
                             got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data); end
            end
            n_tests++;
            if (got_cnt != exp_q.size()) begin n_fail++;
                $display("FAIL %s dut%0d instr_count got %0d want %0d", tag, k, got_cnt, exp_q.size()); end
            n_tests++;
            if (got_ovf !== ovf) begin n_fail++;
                $display("FAIL %s dut%0d overflow got %b want %b", tag, k, got_ovf, ovf); end
            n_tests++;
            if (got_done !== (cstep >= 0)) begin n_fail++;
                $display("FAIL %s dut%0d load_done got %b want %b", tag, k, got_done, cstep >= 0); end
            n_tests++;
            if (got_crst !== (cstep < 0)) begin n_fail++;
                $display("FAIL %s dut%0d cpu_reset got %b want %b", tag, k, got_crst, cstep < 0); end
            for (int i = 0; i < st_a.size(); i++) begin
                if (cstep < 0 || i < cstep) exp_st = 0;
                else if (i == cstep)        exp_st = 1;
                else                        exp_st = MODE_CONT ? 2 : 3;
                got_st = (k == 0) ? st_a[i] : st_b[i];
                n_tests++;
                if (got_st != exp_st) begin n_fail++;
                    $display("FAIL %s dut%0d state@%0d got %0d want %0d", tag, k, i, got_st, exp_st); end
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; FLAG_I = 1'b1; INSTRUCTION_IN = rand_word();
        FLAG_STEP = 1'b1; MODE_CONT = 1'b1; PC_HALTED = 1'b1;
        tick();
        n_tests++; if (a_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", a_state); end
        n_tests++; if (a_we !== 1'b0 || a_addr !== 8'd0 || a_wdata !== 32'd0) begin n_fail++;
            $display("FAIL reset_imem got %b/%0d/%h want 0/0/0", a_we, a_addr, a_wdata); end
        n_tests++; if (a_cpu_reset !== 1'b1 || a_cpu_en !== 1'b0) begin n_fail++;
            $display("FAIL reset_cpu got rst=%b en=%b want rst=1 en=0", a_cpu_reset, a_cpu_en); end
        n_tests++; if (a_count !== 9'd0 || a_done !== 1'b0 || a_ovf !== 1'b0) begin n_fail++;
            $display("FAIL reset_status got cnt=%0d done=%b ovf=%b want 0/0/0", a_count, a_done, a_ovf); end
        n_tests++; if (b_state !== 3'd0 || b_count !== 3'd0 || b_we !== 1'b0) begin n_fail++;
            $display("FAIL reset_small got st=%0d cnt=%0d we=%b want 0/0/0", b_state, b_count, b_we); end
        tick();
        RESET = 1'b0; FLAG_I = 1'b0; FLAG_STEP = 1'b0; PC_HALTED = 1'b0; MODE_CONT = 1'b0;
        wa_q.delete();
        tick(); tick();
        n_tests++; if (wa_q.size() != 0 || a_count !== 9'd0) begin n_fail++;
            $display("FAIL reset_flag_i_ignored got writes=%0d cnt=%0d want 0/0", wa_q.size(), a_count); end
    endtask

    task automatic test_basic_load();
        do_reset(); MODE_CONT = 1'b0;
        add(1, 32'h2001_0005); add(1, 32'h2002_0003); add(1, HALT);
        play_load("basic");
    endtask

    task automatic test_gaps();
        do_reset(); MODE_CONT = 1'b0;
        add(1, rand_word()); add(0, rand_word()); add(0, rand_word()); add(1, rand_word()); add(1, HALT);
        play_load("gaps");
    endtask

    task automatic test_overflow();
        do_reset(); MODE_CONT = 1'b0;
        repeat (5) add(1, rand_word());
        add(1, HALT);
        play_load("overflow");
        do_reset(); MODE_CONT = 1'b1;
        repeat (3) add(1, rand_word());
        add(1, HALT); add(1, rand_word());
        play_load("halt_last_slot");
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 8; it++) begin
            int n;
            do_reset(); MODE_CONT = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 9);
            for (int j = 0; j < n; j++) begin
                while ($urandom_range(0, 3) == 0) add(0, rand_word());
                add(1, rand_word());
            end
            add(1, HALT);
            repeat ($urandom_range(0, 2)) add(1, rand_word());
            play_load("random");
        end
    endtask

    task automatic test_step();
        int npulse, w, exp_evt;
        do_reset(); MODE_CONT = 1'b0;
        FLAG_STEP = 1'b1;   // edge lands in LOAD and must be discarded
        add(1, rand_word()); add(1, rand_word()); add(1, HALT);
        play_load("step_load");
        en_cycles = 0; en_pulses = 0;
        repeat (3) begin
            tick();
            n_tests++; if (a_cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_held_from_load got en=%b want 0", a_cpu_en); end
        end
        FLAG_STEP = 1'b0; tick();
        npulse = $urandom_range(4, 7); exp_evt = 0;
        for (int p = 0; p < npulse; p++) begin
            w = (p < 3) ? 1 : (p == 3) ? 5 : $urandom_range(1, 4);
            FLAG_STEP = 1'b1; tick(); exp_evt++;
            n_tests++; if (a_cpu_en !== 1'b1) begin n_fail++; $display("FAIL step_pulse%0d got en=%b want 1", p, a_cpu_en); end
            for (int j = 1; j < w; j++) begin
                tick();
                n_tests++; if (a_cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_held%0d got en=%b want 0", p, a_cpu_en); end
            end
            FLAG_STEP = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                tick();
                n_tests++; if (a_cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_gap%0d got en=%b want 0", p, a_cpu_en); end
            end
        end
        n_tests++; if (en_pulses != exp_evt || en_cycles != exp_evt) begin n_fail++;
            $display("FAIL step_totals got pulses=%0d cycles=%0d want %0d", en_pulses, en_cycles, exp_evt); end
        FLAG_STEP = 1'b1; PC_HALTED = 1'b1; tick();
        n_tests++; if (a_state !== 3'd4 || a_cpu_en !== 1'b0) begin n_fail++;
            $display("FAIL step_halt got st=%0d en=%b want 4/0", a_state, a_cpu_en); end
        PC_HALTED = 1'b0; FLAG_STEP = 1'b0; tick();
        repeat (2) begin FLAG_STEP = 1'b1; tick(); FLAG_STEP = 1'b0; tick(); end
        n_tests++; if (en_cycles != exp_evt || a_state !== 3'd4 || a_done !== 1'b1) begin n_fail++;
            $display("FAIL step_done_terminal got cycles=%0d st=%0d done=%b want %0d/4/1", en_cycles, a_state, a_done, exp_evt); end
    endtask

    task automatic test_run();
        int n;
        logic [8:0] cnt;
        do_reset(); MODE_CONT = 1'b1;
        repeat ($urandom_range(1, 6)) add(1, rand_word());
        add(1, HALT);
        play_load("run_load");
        n_tests++; if (a_cpu_en !== 1'b1) begin n_fail++; $display("FAIL run_entry got en=%b want 1", a_cpu_en); end
        MODE_CONT = 1'b0;   // late mode change must not matter
        n = $urandom_range(3, 12);
        repeat (n) begin
            FLAG_STEP = 1'($urandom_range(0, 1));
            tick();
            n_tests++; if (a_cpu_en !== 1'b1 || a_state !== 3'd2) begin n_fail++;
                $display("FAIL run_continuous got en=%b st=%0d want 1/2", a_cpu_en, a_state); end
        end
        PC_HALTED = 1'b1; tick();
        n_tests++; if (a_cpu_en !== 1'b0 || a_state !== 3'd4) begin n_fail++;
            $display("FAIL run_halt got en=%b st=%0d want 0/4", a_cpu_en, a_state); end
        cnt = a_count;
        PC_HALTED = 1'b0; FLAG_I = 1'b1; INSTRUCTION_IN = rand_word(); MODE_CONT = 1'b1;
        wa_q.delete();
        repeat (3) begin FLAG_STEP = ~FLAG_STEP; tick(); end
        FLAG_I = 1'b0; tick();
        n_tests++; if (a_state !== 3'd4 || a_cpu_en !== 1'b0 || wa_q.size() != 0 || a_count !== cnt) begin n_fail++;
            $display("FAIL run_done_frozen got st=%0d en=%b writes=%0d cnt=%0d want 4/0/0/%0d",
                     a_state, a_cpu_en, wa_q.size(), a_count, cnt); end
        FLAG_STEP = 1'b0;
    endtask

    task automatic test_reset_in_run();
        do_reset(); MODE_CONT = 1'b1;
        add(1, rand_word()); add(1, HALT);
        play_load("rir_load");
        RESET = 1'b1; FLAG_I = 1'b1; INSTRUCTION_IN = rand_word();
        tick();
        n_tests++; if (a_state !== 3'd0 || a_cpu_en !== 1'b0 || a_cpu_reset !== 1'b1 || a_we !== 1'b0) begin n_fail++;
            $display("FAIL rir_ctrl got st=%0d en=%b rst=%b we=%b want 0/0/1/0", a_state, a_cpu_en, a_cpu_reset, a_we); end
        n_tests++; if (a_count !== 9'd0 || a_done !== 1'b0 || a_addr !== 8'd0 || a_wdata !== 32'd0) begin n_fail++;
            $display("FAIL rir_data got cnt=%0d done=%b addr=%0d wd=%h want 0/0/0/0", a_count, a_done, a_addr, a_wdata); end
        RESET = 1'b0; FLAG_I = 1'b0;
        stim_q.delete();
        add(1, rand_word()); add(0, rand_word()); add(1, rand_word()); add(1, HALT);
        play_load("rir_reload");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gaps();
        test_overflow();
        test_random_loads();
        test_step();
        test_run();
        test_reset_in_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
